// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, default vectors, word widths
// and the opcode constants that decode also uses.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] IRQ_VECTOR_DEFAULT = 32'h0000_0030;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ISR  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // IF/ID payload
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_pkt_t;

  // Sequential successor of a word address, wrapping at the memory size
  function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] pc,
                                                input int unsigned    bytes);
    return (pc + 32'd4) & 32'(bytes - 1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority select for the fetch unit: next pc, next state,
// flush/issue strobes, fault and interrupt-take indications.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned       IMEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
  input  fetch_state_e      state,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  input  logic              advance,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              eret,
  input  logic              irq,
  output fetch_state_e      state_nxt_c,
  output logic [ADDR_W-1:0] pc_nxt_c,
  output logic              flush_c,
  output logic              issue_c,
  output logic              fault_set_c,
  output logic              take_irq_c
);

  localparam logic [ADDR_W-1:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  logic bad_target;
  assign bad_target = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_WORD);

  // Priority: halt > redirect > eret > irq > sequential
  always_comb begin
    state_nxt_c = state;
    pc_nxt_c    = pc;
    flush_c     = 1'b0;
    issue_c     = 1'b0;
    fault_set_c = 1'b0;
    take_irq_c  = 1'b0;
    case (state)
      ST_BOOT: state_nxt_c = ST_RUN;
      ST_RUN, ST_ISR: begin
        if (halt) begin
          flush_c     = 1'b1;
          state_nxt_c = ST_HALT;
        end else if (redirect_valid) begin
          flush_c = 1'b1;
          if (bad_target) begin
            fault_set_c = 1'b1;
            state_nxt_c = ST_HALT;
          end else begin
            pc_nxt_c = redirect_target;
          end
        end else if (eret && state == ST_ISR) begin
          flush_c     = 1'b1;
          pc_nxt_c    = epc;
          state_nxt_c = ST_RUN;
        end else if (irq && state == ST_RUN) begin
          flush_c     = 1'b1;
          take_irq_c  = 1'b1;
          pc_nxt_c    = IRQ_VECTOR;
          state_nxt_c = ST_ISR;
        end else if (advance) begin
          issue_c  = 1'b1;
          pc_nxt_c = wrap_pc(pc, IMEM_BYTES);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives a single-entry IF/ID
// register with valid/ready, and handles redirect, interrupt, eret and halt.
module ifetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT,
  parameter int unsigned       IMEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              irq,
  output logic              irq_ack,
  input  logic              eret,
  output logic [ADDR_W-1:0] epc,
  input  logic              halt,
  output logic              fault
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  fetch_pkt_t        out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              irq_ack_q, irq_ack_d;
  logic              fault_q, fault_d;

  logic flush_c, issue_c, fault_set_c, take_irq_c, advance_c;

  assign advance_c = !out_valid_q || out_ready;

  pc_next_sel #(
    .IMEM_BYTES (IMEM_BYTES),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_sel (
    .state           (state_q),
    .pc              (pc_q),
    .epc             (epc_q),
    .advance         (advance_c),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .eret            (eret),
    .irq             (irq),
    .state_nxt_c     (state_d),
    .pc_nxt_c        (pc_d),
    .flush_c         (flush_c),
    .issue_c         (issue_c),
    .fault_set_c     (fault_set_c),
    .take_irq_c      (take_irq_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Output register next values; a flush always discards the held word
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    epc_d       = epc_q;
    fault_d     = fault_q;
    irq_ack_d   = 1'b0;
    if (flush_c) begin
      out_valid_d = 1'b0;
    end else if (issue_c) begin
      out_valid_d = 1'b1;
      out_d.inst  = imem_inst;
      out_d.pc    = pc_q;
    end
    if (take_irq_c) begin
      epc_d     = pc_q;
      irq_ack_d = 1'b1;
    end
    if (fault_set_c) fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      irq_ack_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      irq_ack_q   <= irq_ack_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_q.inst;
  assign out_pc    = out_q.pc;
  assign irq_ack   = irq_ack_q;
  assign epc       = epc_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model; a 64-byte instance checks wrap.
module tb_ifetch_ctrl;

  localparam int unsigned IMEM = 1024;
  localparam logic [31:0] IRQV = 32'h0000_0030;
  localparam int M_BOOT = 0, M_RUN = 1, M_ISR = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, out_valid, out_ready, redirect_valid, irq, irq_ack, eret, halt, fault;
  logic [31:0] imem_addr, imem_inst, out_inst, out_pc, redirect_target, epc;

  logic        b_rst_n, b_valid, b_ack, b_fault;
  logic [31:0] b_addr, b_inst, b_out_inst, b_out_pc, b_epc;

  logic [31:0] mem [256];
  assign imem_inst = mem[imem_addr[9:2]];
  assign b_inst    = mem[{4'b0000, b_addr[5:2]}];

  ifetch_ctrl #(.RESET_PC(32'h0), .IRQ_VECTOR(IRQV), .IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .irq(irq), .irq_ack(irq_ack), .eret(eret), .epc(epc), .halt(halt), .fault(fault)
  );

  ifetch_ctrl #(.RESET_PC(32'h0), .IRQ_VECTOR(IRQV), .IMEM_BYTES(64)) dut64 (
    .clk(clk), .rst_n(b_rst_n), .imem_addr(b_addr), .imem_inst(b_inst),
    .out_valid(b_valid), .out_ready(1'b1), .out_inst(b_out_inst), .out_pc(b_out_pc),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .irq(1'b0), .irq_ack(b_ack), .eret(1'b0), .epc(b_epc), .halt(1'b0), .fault(b_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_mode;
  logic [31:0] m_pc, m_epc, m_inst, m_opc;
  logic        m_valid, m_ack, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of the architectural rules, applied to the inputs now driven
  task automatic model_step();
    logic        adv;
    logic [31:0] t;
    if (!rst_n) begin
      m_mode = M_BOOT; m_pc = 32'h0; m_epc = 32'h0; m_inst = 32'h0; m_opc = 32'h0;
      m_valid = 1'b0; m_ack = 1'b0; m_fault = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN || m_mode == M_ISR) begin
        adv = !m_valid || out_ready;
        t   = redirect_target;
        if (halt) begin
          m_mode = M_HALT; m_valid = 1'b0;
        end else if (redirect_valid) begin
          m_valid = 1'b0;
          if ((t % 4) != 0 || t > 32'(IMEM - 4)) begin
            m_fault = 1'b1; m_mode = M_HALT;
          end else begin
            m_pc = t;
          end
        end else if (eret && m_mode == M_ISR) begin
          m_valid = 1'b0; m_pc = m_epc; m_mode = M_RUN;
        end else if (irq && m_mode == M_RUN) begin
          m_epc = m_pc; m_pc = IRQV; m_valid = 1'b0; m_ack = 1'b1; m_mode = M_ISR;
        end else if (adv) begin
          m_inst  = mem[m_pc[9:2]];
          m_opc   = m_pc;
          m_valid = 1'b1;
          m_pc    = 32'((m_pc + 4) % IMEM);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_pc", out_pc, m_opc);
      chk("out_inst", out_inst, m_inst);
    end
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));
    chk("epc", epc, m_epc);
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0001_1020;
    mem[9] = 32'h0800_000B;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    irq = 1'b0; eret = 1'b0; halt = 1'b0; b_rst_n = 1'b0;

    cycle(); cycle();
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_pc", imem_addr, 32'h0);

    // Boot, sequential fetch, stall
    rst_n = 1'b1;
    cycle(); chk("boot_valid", 32'(out_valid), 32'h0);
    cycle(); chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_inst", out_inst, 32'h0001_1020); chk("first_pc", out_pc, 32'h0);
    cycle(); chk("seq_pc4", out_pc, 32'h4);
    cycle(); chk("seq_pc8", out_pc, 32'h8);
    out_ready = 1'b0;
    repeat (3) begin
      cycle(); chk("stall_pc", out_pc, 32'h8); chk("stall_addr", imem_addr, 32'hC);
    end
    out_ready = 1'b1;
    cycle(); chk("release_pc", out_pc, 32'hC);
    cycle(); chk("seq_pc10", out_pc, 32'h10);

    // Redirect to 0x24
    redirect_valid = 1'b1; redirect_target = 32'h24;
    cycle(); redirect_valid = 1'b0;
    chk("redir_flush", 32'(out_valid), 32'h0);
    cycle(); chk("redir_pc", out_pc, 32'h24); chk("redir_inst", out_inst, 32'h0800_000B);

    // Interrupt at pc=0x10, held irq masked in ISR, eret
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("pre_irq_pc", imem_addr, 32'h10);
    irq = 1'b1;
    cycle(); chk("irq_ack", 32'(irq_ack), 32'h1); chk("irq_epc", epc, 32'h10);
    cycle(); chk("isr_ack_low", 32'(irq_ack), 32'h0); chk("isr_pc", out_pc, 32'h30);
    repeat (3) begin
      cycle(); chk("isr_no_reack", 32'(irq_ack), 32'h0);
    end
    irq = 1'b0; eret = 1'b1;
    cycle(); eret = 1'b0; chk("eret_flush", 32'(out_valid), 32'h0);
    cycle(); chk("eret_pc", out_pc, 32'h10);

    // Redirect and irq together
    redirect_valid = 1'b1; redirect_target = 32'h20; irq = 1'b1;
    cycle(); redirect_valid = 1'b0;
    chk("ri_addr", imem_addr, 32'h20); chk("ri_no_ack", 32'(irq_ack), 32'h0);
    cycle(); chk("ri_ack", 32'(irq_ack), 32'h1); chk("ri_epc", epc, 32'h20);
    irq = 1'b0;
    cycle(); chk("ri_isr_pc", out_pc, 32'h30);

    // Misaligned redirect -> fault and halt
    redirect_valid = 1'b1; redirect_target = 32'h26;
    cycle(); redirect_valid = 1'b0;
    chk("fault_set", 32'(fault), 32'h1);
    repeat (3) begin
      cycle(); chk("halt_valid", 32'(out_valid), 32'h0);
    end
    rst_n = 1'b0; cycle(); chk("fault_clear", 32'(fault), 32'h0);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n          = ($urandom_range(99) != 0) && !(m_mode == M_HALT && $urandom_range(5) == 0);
      out_ready      = ($urandom_range(3) != 0);
      halt           = ($urandom_range(199) == 0);
      redirect_valid = ($urandom_range(11) == 0);
      case ($urandom_range(7))
        0:       redirect_target = $urandom;
        1:       redirect_target = {22'h0, 8'($urandom), 2'($urandom_range(3, 1))};
        default: redirect_target = {22'h0, 8'($urandom), 2'b00};
      endcase
      eret = ($urandom_range(9) == 0);
      irq  = ($urandom_range(14) == 0) ? ~irq : irq;
      cycle();
    end
    rst_n = 1'b1; halt = 1'b0; redirect_valid = 1'b0; eret = 1'b0; irq = 1'b0;

    // Wrap at a 64-byte memory
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("w64_boot", 32'(b_valid), 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("w64_valid", 32'(b_valid), 32'h1);
      chk("w64_pc", b_out_pc, 32'((4 * k) % 64));
      chk("w64_inst", b_out_inst, mem[(k % 16)]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
